picosoc_bus_interconnect: RTL

//  Parametrised successor to the PicoSoC address decode/mux. Sits between the picorv32 native memory

---
 rtl/picosoc_bus_interconnect_pkg.sv | 30 +++
 rtl/picosoc_bus_interconnect_timeout.sv | 43 ++++
 rtl/picosoc_bus_interconnect.sv | 167 ++++++++++++++++
 3 files changed

// File: rtl/picosoc_bus_interconnect_pkg.sv
// Shared types and defaults for the PicoSoC bus interconnect.
// The optional error log is enabled with the PICOSOC_BUSIC_ERRLOG_EN macro (see top).
package picosoc_bus_interconnect_pkg;

    // Request FSM encoding; values are fixed so waveforms stay readable across builds.
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } bus_state_e;

    // Read data returned on any error response.
    localparam logic [31:0] ERR_RDATA_DEFAULT = 32'hDEAD_BEEF;

    // Default SoC map for 4 slaves, packed {slave3, slave2, slave1, slave0}:
    // SRAM 1 KiB at 0, SPI flash 1 MiB at 0x0010_0000, cfg/UART regs at 0x0200_0000,
    // iomem 16 MiB at 0x0300_0000.
    localparam logic [4*32-1:0] DEFAULT_SLAVE_BASE = {
        32'h0300_0000, 32'h0200_0000, 32'h0010_0000, 32'h0000_0000
    };
    localparam logic [4*32-1:0] DEFAULT_SLAVE_MASK = {
        32'hFF00_0000, 32'hFFFF_FF00, 32'hFFF0_0000, 32'hFFFF_FC00
    };

    // Width of a slave index; a single slave still needs one bit.
    function automatic int sel_width(input int num_slaves);
        return (num_slaves > 1) ? $clog2(num_slaves) : 1;
    endfunction

endpackage

// File: rtl/picosoc_bus_interconnect_timeout.sv
// Access watchdog: cleared on entry to ACCESS, counts while enabled, flags the last
// allowed cycle. Saturates instead of wrapping.
module picosoc_bus_interconnect_timeout #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic clk_i,
    input  logic reset_i,
    input  logic clear_i,
    input  logic enable_i,
    output logic expire_o
);

    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] SAT  = CNT_W'(TIMEOUT_CYCLES);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    // Next count: clear wins, otherwise count up while enabled and below saturation.
    always_comb begin
        // NOTE: default first so every path assigns count_d; otherwise a latch is inferred.
        count_d = count_q;
        if (clear_i) begin
            count_d = '0;
        end else if (enable_i && (count_q != SAT)) begin
            count_d = count_q + 1'b1;
        end
    end

    // Counter register with synchronous reset.
    always_ff @(posedge clk_i) begin
        // NOTE: non-blocking in clocked blocks so every flop samples pre-edge values.
        if (reset_i) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign expire_o = enable_i && (count_q == LAST);

endmodule

// File: rtl/picosoc_bus_interconnect.sv
// Address decode / handshake / read-data mux between the picorv32 native memory port
// and NUM_SLAVES targets. Unmapped and hung accesses end in an error response.
// Optional feature macro: PICOSOC_BUSIC_ERRLOG_EN (err_addr capture + error counter).
module picosoc_bus_interconnect
    import picosoc_bus_interconnect_pkg::*;
#(
    parameter int                           NUM_SLAVES     = 4,
    parameter int                           DATA_W         = 32,
    parameter int                           ADDR_W         = 32,
    parameter logic [NUM_SLAVES*ADDR_W-1:0] SLAVE_BASE     = DEFAULT_SLAVE_BASE,
    parameter logic [NUM_SLAVES*ADDR_W-1:0] SLAVE_MASK     = DEFAULT_SLAVE_MASK,
    parameter int                           TIMEOUT_CYCLES = 255,
    parameter logic [DATA_W-1:0]            ERR_RDATA      = DATA_W'(ERR_RDATA_DEFAULT)
) (
    input  logic                         clk_i,
    input  logic                         reset_i,
    input  logic                         mem_valid_i,
    input  logic [ADDR_W-1:0]            mem_addr_i,
    input  logic [DATA_W/8-1:0]          mem_wstrb_i,
    input  logic [DATA_W-1:0]            mem_wdata_i,
    output logic                         mem_ready_o,
    output logic [DATA_W-1:0]            mem_rdata_o,
    output logic [NUM_SLAVES-1:0]        s_valid_o,
    input  logic [NUM_SLAVES-1:0]        s_ready_i,
    input  logic [NUM_SLAVES*DATA_W-1:0] s_rdata_i,
    output logic [ADDR_W-1:0]            s_addr_o,
    output logic [DATA_W/8-1:0]          s_wstrb_o,
    output logic [DATA_W-1:0]            s_wdata_o,
    output logic                         bus_err_o,
    output logic [ADDR_W-1:0]            err_addr_o
);

    localparam int SEL_W = sel_width(NUM_SLAVES);

    bus_state_e        state_q, state_d;
    logic [SEL_W-1:0]  sel_q, sel_d;
    logic              err_q, err_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;

    logic [NUM_SLAVES-1:0] hit;
    logic [DATA_W-1:0]     slave_rdata [NUM_SLAVES];
    logic [SEL_W-1:0]      hit_sel;
    logic                  any_hit;
    logic                  timer_clear;
    logic                  timer_expire;

    // Address, strobes and write data reach the slaves unregistered.
    assign s_addr_o  = mem_addr_i;
    assign s_wstrb_o = mem_wstrb_i;
    assign s_wdata_o = mem_wdata_i;

    // Per-slave window match and read-data unpacking.
    for (genvar i = 0; i < NUM_SLAVES; i++) begin : g_slave
        assign hit[i] = (mem_addr_i & SLAVE_MASK[i*ADDR_W +: ADDR_W])
                        == SLAVE_BASE[i*ADDR_W +: ADDR_W];
        assign slave_rdata[i] = s_rdata_i[i*DATA_W +: DATA_W];
    end

    assign any_hit = |hit;

    // Priority encode: scanning downwards lets the lowest-index hit overwrite the rest.
    always_comb begin
        hit_sel = '0;
        for (int i = NUM_SLAVES - 1; i >= 0; i--) begin
            if (hit[i]) hit_sel = SEL_W'(i);
        end
    end

    picosoc_bus_interconnect_timeout #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timeout (
        .clk_i    (clk_i),
        .reset_i  (reset_i),
        .clear_i  (timer_clear),
        .enable_i (state_q == ST_ACCESS),
        .expire_o (timer_expire)
    );

    // Next-state logic: decode in IDLE, wait for the selected slave or the watchdog in ACCESS.
    always_comb begin
        state_d     = state_q;
        sel_d       = sel_q;
        err_d       = err_q;
        rdata_d     = rdata_q;
        timer_clear = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (mem_valid_i) begin
                    sel_d = hit_sel;
                    if (any_hit) begin
                        state_d     = ST_ACCESS;
                        timer_clear = 1'b1;
                    end else begin
                        state_d = ST_RESP;
                        err_d   = 1'b1;
                        rdata_d = ERR_RDATA;
                    end
                end
            end
            ST_ACCESS: begin
                // A withdrawn request is dropped silently; a ready beats a same-cycle timeout.
                if (!mem_valid_i) begin
                    state_d = ST_IDLE;
                end else if (s_ready_i[sel_q]) begin
                    state_d = ST_RESP;
                    err_d   = 1'b0;
                    rdata_d = slave_rdata[sel_q];
                end else if (timer_expire) begin
                    state_d = ST_RESP;
                    err_d   = 1'b1;
                    rdata_d = ERR_RDATA;
                end
            end
            ST_RESP: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // FSM and response registers.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q <= ST_IDLE;
            sel_q   <= '0;
            err_q   <= 1'b0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            err_q   <= err_d;
            rdata_q <= rdata_d;
        end
    end

    // One-hot request to the selected slave while in ACCESS.
    always_comb begin
        s_valid_o = '0;
        if (state_q == ST_ACCESS) s_valid_o[sel_q] = 1'b1;
    end

    assign mem_ready_o = (state_q == ST_RESP);
    assign bus_err_o   = mem_ready_o && err_q;
    assign mem_rdata_o = rdata_q;

`ifdef PICOSOC_BUSIC_ERRLOG_EN
    logic              err_capture;
    logic [ADDR_W-1:0] err_addr_q;
    logic [15:0]       err_cnt_q;

    assign err_capture = (state_q != ST_RESP) && (state_d == ST_RESP) && err_d;

    // Error log: last errored address and a saturating count for debug.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            err_addr_q <= '0;
            err_cnt_q  <= '0;
        end else if (err_capture) begin
            err_addr_q <= mem_addr_i;
            if (err_cnt_q != 16'hFFFF) err_cnt_q <= err_cnt_q + 16'd1;
        end
    end

    assign err_addr_o = err_addr_q;
`else
    assign err_addr_o = '0;
`endif

endmodule
